// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CH independent programmable clock/tick generators.
// Each channel counts 0..div and, at the terminal count, emits a one-cycle
// tick plus either a square-wave toggle (mode 0) or a one-cycle pulse
// (mode 1) on clk_out.
//
// Divisor/mode updates to a running channel are staged in a shadow register
// and only take effect at that channel's next terminal count. The current
// period therefore always finishes under the old settings, and no runt or
// truncated period is ever produced.
//
// While a shadow update is pending, further writes to that channel are
// refused (cfg_ready low) and flagged on cfg_err one cycle later.
//
// A global sync restarts every enabled channel from zero with its outputs
// low, so all enabled channels come back into phase.
module clkdiv_multi #(
    parameter int unsigned       CLK_HZ  = 50_000_000,
    parameter int unsigned       CH      = 4,
    parameter int unsigned       CNT_W   = 28,
    // Reset divisor: one toggle per second of CLK_HZ (28'd49_999_999 at 50 MHz).
    parameter logic [CNT_W-1:0]  DEF_DIV = CNT_W'(CLK_HZ - 1),
    parameter logic [CH-1:0]     RST_EN  = {CH{1'b1}},
    localparam int unsigned      CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             sync,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    // Pending flags of all channels. The vector is padded to the full cfg_ch
    // range so that an index with no channel behind it reads as "not pending":
    // a write to a non-existent channel is accepted and simply has no effect.
    logic [CH-1:0]          pend;
    logic [(1<<CH_W)-1:0]   pend_pad;
    logic                   wr_ok;

    // Zero-extend the per-channel pending flags to the full cfg_ch range.
    always_comb begin
        pend_pad           = '0;
        pend_pad[CH-1:0]   = pend;
    end

    // A channel can take a write only while no shadow update is waiting.
    assign cfg_ready = !pend_pad[cfg_ch];
    assign wr_ok     = cfg_wr && cfg_ready;

    // Flag a refused write one cycle after it was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ready;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] sh_div;
        logic             mode;
        logic             sh_mode;
        logic             en;
        logic             pending;
        logic             out_q;
        logic             tick_q;
        logic             wr_hit;
        logic             tc;

        assign wr_hit = wr_ok && (cfg_ch == CH_W'(c));
        assign tc     = (cnt == div);

        // Channel counter, output generation and configuration handling.
        // Priority: an accepted write is handled before sync, so a write
        // presented together with sync is applied at once rather than
        // being left pending.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                div     <= DEF_DIV;
                sh_div  <= DEF_DIV;
                mode    <= 1'b0;
                sh_mode <= 1'b0;
                en      <= RST_EN[c];
                pending <= 1'b0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (wr_hit && !cfg_en) begin
                // Disable: stop immediately and load settings directly.
                en      <= 1'b0;
                cnt     <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                div     <= cfg_div;
                mode    <= cfg_mode;
                pending <= 1'b0;
            end else if (wr_hit && !en) begin
                // Enable from idle: start a fresh period under the new settings.
                en      <= 1'b1;
                cnt     <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                div     <= cfg_div;
                mode    <= cfg_mode;
                pending <= 1'b0;
            end else if (sync && en) begin
                // Restart in phase; a simultaneous write outranks any older shadow.
                if (wr_hit) begin
                    div  <= cfg_div;
                    mode <= cfg_mode;
                end else if (pending) begin
                    div  <= sh_div;
                    mode <= sh_mode;
                end
                pending <= 1'b0;
                cnt     <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (en) begin
                if (tc) begin
                    // Terminal count completes under the current settings.
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    out_q  <= mode ? 1'b1 : !out_q;
                    if (pending) begin
                        div     <= sh_div;
                        mode    <= sh_mode;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                    if (mode) begin
                        out_q <= 1'b0;
                    end
                end
                // A write to a running channel is staged; it was accepted, so
                // no older shadow can exist and the apply above cannot clash.
                if (wr_hit) begin
                    sh_div  <= cfg_div;
                    sh_mode <= cfg_mode;
                    pending <= 1'b1;
                end
            end
        end

        assign clk_out[c] = out_q;
        assign tick[c]    = tick_q;
        assign pend[c]    = pending;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed testbench for clkdiv_multi: 4 channels, DEF_DIV = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
// k counts rising edges since the most recent reset release.
module tb_clkdiv_multi;

    localparam int unsigned CH    = 4;
    localparam int unsigned CNT_W = 28;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_wr;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             cfg_en;
    logic             cfg_ready;
    logic             cfg_err;
    logic             sync;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;

    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;

    clkdiv_multi #(
        .CLK_HZ  (50_000_000),
        .CH      (CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (28'd4),
        .RST_EN  (4'hF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_en    (cfg_en),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic drive_write(input logic [1:0] ch, input logic [CNT_W-1:0] d,
                               input logic m, input logic e);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = d;
        cfg_mode = m;
        cfg_en   = e;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        cfg_wr   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_div  = '0;
        cfg_mode = 1'b0;
        cfg_en   = 1'b0;
        sync     = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (clk_out !== 4'h0) begin miscompares++; $display("FAIL reset_clk_out got %h want %h", clk_out, 4'h0); end
        vectors++; if (tick !== 4'h0) begin miscompares++; $display("FAIL reset_tick got %h want %h", tick, 4'h0); end
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    endtask

    // Every channel: tick every 5 edges, clk_out toggles every 5 edges.
    task automatic test_default_cadence();
        logic [CH-1:0] exp_out, exp_tick;
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            exp_tick = (k % 5 == 0) ? 4'hF : 4'h0;
            exp_out  = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
            vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL cadence_tick k=%0d got %h want %h", k, tick, exp_tick); end
            vectors++; if (clk_out !== exp_out) begin miscompares++; $display("FAIL cadence_clk_out k=%0d got %h want %h", k, clk_out, exp_out); end
        end
    endtask

    // ch1 mid-count (cnt=2): div=2, mode=1 goes to the shadow.
    task automatic test_shadow_write();
        step();
        step();
        drive_write(2'd1, 28'd2, 1'b1, 1'b1);
        #1;
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL shadow_ready_before got %b want 1", cfg_ready); end
        step();
        cfg_wr = 1'b0;
        #1;
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL shadow_ready_low got %b want 0", cfg_ready); end
        vectors++; if (clk_out[1] !== 1'b0) begin miscompares++; $display("FAIL shadow_old_out k=%0d got %b want 0", k, clk_out[1]); end
        vectors++; if (tick[1] !== 1'b0) begin miscompares++; $display("FAIL shadow_old_tick k=%0d got %b want 0", k, tick[1]); end
    endtask

    // Second write while ch1 is pending: refused, cfg_err pulses once.
    task automatic test_dropped_write();
        drive_write(2'd1, 28'd7, 1'b0, 1'b1);
        step();
        cfg_wr = 1'b0;
        #1;
        vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL drop_err_pulse got %b want 1", cfg_err); end
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL drop_ready_low got %b want 0", cfg_ready); end
        step();
        vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL drop_err_clear got %b want 0", cfg_err); end
        vectors++; if (clk_out[1] !== 1'b1) begin miscompares++; $display("FAIL apply_old_toggle got %b want 1", clk_out[1]); end
        vectors++; if (tick[1] !== 1'b1) begin miscompares++; $display("FAIL apply_old_tick got %b want 1", tick[1]); end
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL apply_ready_high got %b want 1", cfg_ready); end
        vectors++; if (clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL apply_ch0_out got %b want 1", clk_out[0]); end
    endtask

    // ch1 now pulses every 3 edges (applied at k=35); ch0 keeps period 10.
    task automatic test_pulse_cadence();
        logic e1, e0;
        for (int i = 0; i < 15; i++) begin
            step();
            e1 = ((k - 35) % 3 == 0);
            e0 = ((k / 5) % 2 == 1);
            vectors++; if (clk_out[1] !== e1) begin miscompares++; $display("FAIL pulse_out k=%0d got %b want %b", k, clk_out[1], e1); end
            vectors++; if (tick[1] !== e1) begin miscompares++; $display("FAIL pulse_tick k=%0d got %b want %b", k, tick[1], e1); end
            vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL pulse_err k=%0d got %b want 0", k, cfg_err); end
            vectors++; if (clk_out[0] !== e0) begin miscompares++; $display("FAIL pulse_ch0 k=%0d got %b want %b", k, clk_out[0], e0); end
        end
    endtask

    // Disable ch2, hold it off, then re-enable at div=0 (clk/2).
    task automatic test_disable_reenable();
        drive_write(2'd2, 28'd9, 1'b0, 1'b0);
        #1;
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL dis_ready got %b want 1", cfg_ready); end
        step();
        cfg_wr = 1'b0;
        vectors++; if (clk_out[2] !== 1'b0) begin miscompares++; $display("FAIL dis_out k=%0d got %b want 0", k, clk_out[2]); end
        vectors++; if (tick[2] !== 1'b0) begin miscompares++; $display("FAIL dis_tick k=%0d got %b want 0", k, tick[2]); end
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++; if ({clk_out[2], tick[2]} !== 2'b00) begin miscompares++; $display("FAIL dis_hold k=%0d got %b want 00", k, {clk_out[2], tick[2]}); end
        end
        drive_write(2'd2, 28'd0, 1'b0, 1'b1);
        step();
        cfg_wr = 1'b0;
        vectors++; if ({clk_out[2], tick[2]} !== 2'b00) begin miscompares++; $display("FAIL en_first k=%0d got %b want 00", k, {clk_out[2], tick[2]}); end
        for (int j = 1; j <= 8; j++) begin
            step();
            vectors++; if (clk_out[2] !== 1'(j % 2)) begin miscompares++; $display("FAIL div0_out j=%0d got %b want %b", j, clk_out[2], 1'(j % 2)); end
            vectors++; if (tick[2] !== 1'b1) begin miscompares++; $display("FAIL div0_tick j=%0d got %b want 1", j, tick[2]); end
        end
    endtask

    // ch0 div3 stays pending, ch1 div5 written on its own terminal count,
    // ch2 div7 written together with sync; ch3 keeps div4.
    task automatic test_sync();
        int unsigned dv [4] = '{3, 5, 7, 4};
        logic [CH-1:0] exp_out, exp_tick;
        drive_write(2'd0, 28'd3, 1'b0, 1'b1);
        step();
        drive_write(2'd1, 28'd5, 1'b0, 1'b1);
        step();
        cfg_wr = 1'b0;
        cfg_ch = 2'd1;
        #1;
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL tc_write_pending got %b want 0", cfg_ready); end
        cfg_ch = 2'd0;
        #1;
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL ch0_pending got %b want 0", cfg_ready); end
        drive_write(2'd2, 28'd7, 1'b0, 1'b1);
        sync = 1'b1;
        step();
        sync   = 1'b0;
        cfg_wr = 1'b0;
        vectors++; if (clk_out !== 4'h0) begin miscompares++; $display("FAIL sync_out got %h want 0", clk_out); end
        vectors++; if (tick !== 4'h0) begin miscompares++; $display("FAIL sync_tick got %h want 0", tick); end
        cfg_ch = 2'd0;
        #1;
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL sync_ready0 got %b want 1", cfg_ready); end
        cfg_ch = 2'd1;
        #1;
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL sync_ready1 got %b want 1", cfg_ready); end
        for (int j = 1; j <= 17; j++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                exp_tick[c] = (j % (dv[c] + 1) == 0);
                exp_out[c]  = ((j / (dv[c] + 1)) % 2 == 1);
            end
            vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL sync_run_tick j=%0d got %h want %h", j, tick, exp_tick); end
            vectors++; if (clk_out !== exp_out) begin miscompares++; $display("FAIL sync_run_out j=%0d got %h want %h", j, clk_out, exp_out); end
        end
    endtask

    // Reset mid-period clears outputs before any clock edge; cadence resumes.
    task automatic test_async_reset();
        logic [CH-1:0] exp_out, exp_tick;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (clk_out !== 4'h0) begin miscompares++; $display("FAIL arst_out got %h want 0", clk_out); end
        vectors++; if (tick !== 4'h0) begin miscompares++; $display("FAIL arst_tick got %h want 0", tick); end
        @(posedge clk);
        #1;
        vectors++; if (clk_out !== 4'h0) begin miscompares++; $display("FAIL arst_hold got %h want 0", clk_out); end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_tick = (k % 5 == 0) ? 4'hF : 4'h0;
            exp_out  = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
            vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL resume_tick k=%0d got %h want %h", k, tick, exp_tick); end
            vectors++; if (clk_out !== exp_out) begin miscompares++; $display("FAIL resume_out k=%0d got %h want %h", k, clk_out, exp_out); end
        end
        cfg_ch = 2'd1;
        #1;
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL resume_ready got %b want 1", cfg_ready); end
    endtask

    initial begin
        test_reset();
        test_default_cadence();
        test_shadow_write();
        test_dropped_write();
        test_pulse_cadence();
        test_disable_reenable();
        test_sync();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
